// File: rtl/conv_tile_seq_pkg.sv
// Shared accelerator package: tile sequencer state encoding, counter width
// and a saturating cycle-counter helper.
package conv_tile_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PRE_COMP,
    COMPUTE,
    DRAIN,
    STORE,
    DONE
  } tile_state_t;

  // Width of the shared PRE_COMP / DRAIN delay counter; must cover DRAIN_W.
  localparam int CNT_W = 16;

  // Increment a 32-bit cycle count, sticking at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/conv_tile_seq_done_latch.sv
// Sticky done-flag bank: clear loads a preset pattern at tile accept,
// then every pulse seen while enabled is OR-ed into the flags.
module sticky_done_latch
  import conv_tile_seq_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] clr_val,
  input  logic         en,
  input  logic [W-1:0] pulse,
  output logic [W-1:0] flags
);

  // Flags accumulate pulses until the next accept reloads the preset.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= '0;
    end else if (clr) begin
      flags <= clr_val;
    end else if (en) begin
      flags <= flags | pulse;
    end
  end

endmodule

// File: rtl/conv_tile_seq.sv
// Convolution tile sequencer: issues loads, waits for all of them, delays
// into the conv core, drains, issues the store and reports tile completion.
module conv_tile_seq
  import conv_tile_seq_pkg::*;
#(
  parameter int CW         = 16,
  parameter int NUM_LD     = 3,
  parameter int OUT_LD_IDX = 2,
  parameter int COMP_DELAY = 5,
  parameter int DRAIN_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tile_start,
  input  logic [CW-1:0]      tile_base_m,
  input  logic               zero_init_en,
  input  logic [DRAIN_W-1:0] drain_cycles,
  output logic [NUM_LD-1:0]  ld_start,
  input  logic [NUM_LD-1:0]  ld_done,
  output logic               compute_start,
  input  logic               compute_done,
  output logic               store_start,
  input  logic               st_fifo_done,
  input  logic               st_wmst_done,
  output logic               zero_init,
  output logic               tile_busy,
  output logic               tile_done,
  output logic               tile_reset,
  output logic [31:0]        cycle_count,
  output logic               err_start_busy
);

  // Last PRE_COMP count value; a zero delay still spends one PRE_COMP cycle.
  localparam logic [CNT_W-1:0] PRE_LAST = (COMP_DELAY > 0) ? CNT_W'(COMP_DELAY - 1) : '0;

  tile_state_t        state, next_state;
  logic               accept;
  logic               zi_now;
  logic [NUM_LD-1:0]  ld_preset;
  logic [NUM_LD-1:0]  ld_flags;
  logic [1:0]         st_flags;
  logic [CNT_W-1:0]   cnt;
  logic [DRAIN_W-1:0] drain_q;
  logic [31:0]        run_cnt;

  assign accept    = (state == IDLE) && tile_start;
  assign zi_now    = zero_init_en && (tile_base_m == '0);
  assign ld_preset = zi_now ? (NUM_LD'(1) << OUT_LD_IDX) : '0;
  assign tile_busy = (state != IDLE);

  sticky_done_latch #(.W(NUM_LD)) u_ld_flags (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .clr_val (ld_preset),
    .en      (state == LOAD),
    .pulse   (ld_done),
    .flags   (ld_flags)
  );

  sticky_done_latch #(.W(2)) u_st_flags (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .clr_val (2'b00),
    .en      (state == STORE),
    .pulse   ({st_wmst_done, st_fifo_done}),
    .flags   (st_flags)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus the single-cycle pulses tied to state exits.
  always_comb begin
    next_state    = state;
    compute_start = 1'b0;
    store_start   = 1'b0;
    tile_done     = 1'b0;
    case (state)
      IDLE:     if (tile_start) next_state = LOAD;
      LOAD:     if (&ld_flags) next_state = PRE_COMP;
      PRE_COMP: begin
        if (cnt >= PRE_LAST) begin
          compute_start = 1'b1;
          next_state    = COMPUTE;
        end
      end
      COMPUTE:  if (compute_done) next_state = DRAIN;
      DRAIN: begin
        if (cnt >= CNT_W'(drain_q)) begin
          store_start = 1'b1;
          next_state  = STORE;
        end
      end
      STORE:    if (&st_flags) next_state = DONE;
      DONE: begin
        tile_done  = 1'b1;
        next_state = IDLE;
      end
      default:  next_state = IDLE;
    endcase
  end

  // Per-tile sampled settings, delay counter, tile cycle count and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      drain_q        <= '0;
      zero_init      <= 1'b0;
      ld_start       <= '0;
      tile_reset     <= 1'b0;
      run_cnt        <= '0;
      cycle_count    <= '0;
      err_start_busy <= 1'b0;
    end else begin
      cnt        <= (next_state != state) ? '0 : cnt + 1'b1;
      ld_start   <= accept ? ~ld_preset : '0;
      tile_reset <= (state == DONE);
      if (accept) begin
        drain_q   <= drain_cycles;
        zero_init <= zi_now;
        run_cnt   <= 32'd1;
      end else if (state != IDLE) begin
        run_cnt <= sat_inc32(run_cnt);
      end
      if (state == DONE) begin
        cycle_count <= sat_inc32(run_cnt);
        zero_init   <= 1'b0;
      end
      if (tile_start && (state != IDLE)) begin
        err_start_busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_tile_seq.sv
// Self-checking bench for conv_tile_seq: each tile is planned as absolute
// event times relative to the accept cycle, and the expected output of
// every cycle is derived from that plan with plain arithmetic.
module tb_conv_tile_seq;

  localparam int COMP_DELAY = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        tile_start;
  logic [15:0] tile_base_m;
  logic        zero_init_en;
  logic [7:0]  drain_cycles;
  logic [2:0]  ld_start;
  logic [2:0]  ld_done;
  logic        compute_start;
  logic        compute_done;
  logic        store_start;
  logic        st_fifo_done;
  logic        st_wmst_done;
  logic        zero_init;
  logic        tile_busy;
  logic        tile_done;
  logic        tile_reset;
  logic [31:0] cycle_count;
  logic        err_start_busy;

  int checks = 0;
  int passed = 0;

  // Tile plan
  bit          p_zi_en;
  logic [15:0] p_base;
  int          p_drain;
  int          p_off[3];
  int          p_cdo;
  int          p_fo;
  int          p_wo;
  bit          p_poke;
  bit          p_spur;
  bit          p_abort;

  // Reference state carried between tiles
  logic [31:0] countPrev = '0;
  bit          errPrev = 1'b0;

  conv_tile_seq #(
    .CW(16), .NUM_LD(3), .OUT_LD_IDX(2), .COMP_DELAY(COMP_DELAY), .DRAIN_W(8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .tile_start     (tile_start),
    .tile_base_m    (tile_base_m),
    .zero_init_en   (zero_init_en),
    .drain_cycles   (drain_cycles),
    .ld_start       (ld_start),
    .ld_done        (ld_done),
    .compute_start  (compute_start),
    .compute_done   (compute_done),
    .store_start    (store_start),
    .st_fifo_done   (st_fifo_done),
    .st_wmst_done   (st_wmst_done),
    .zero_init      (zero_init),
    .tile_busy      (tile_busy),
    .tile_done      (tile_done),
    .tile_reset     (tile_reset),
    .cycle_count    (cycle_count),
    .err_start_busy (err_start_busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic planTile(input bit zi_en, input logic [15:0] base, input int drain,
                          input int o0, input int o1, input int o2, input int cdo,
                          input int fo, input int wo, input bit poke, input bit spur,
                          input bit abort);
    p_zi_en  = zi_en;
    p_base   = base;
    p_drain  = drain;
    p_off[0] = o0;
    p_off[1] = o1;
    p_off[2] = o2;
    p_cdo    = cdo;
    p_fo     = fo;
    p_wo     = wo;
    p_poke   = poke;
    p_spur   = spur;
    p_abort  = abort;
  endtask

  // Runs one planned tile; entered and left just after a rising edge.
  task automatic applyStimulus();
    logic [2:0]  mask;
    logic [9:0]  ctlObs, ctlExp;
    logic [31:0] cntExp;
    bit          zi;
    int L, cs, cd, ss, fifoT, wmstT, td, ab, last;

    zi   = p_zi_en && (p_base == 16'd0);
    mask = zi ? 3'b011 : 3'b111;
    L = 1;
    for (int i = 0; i < 3; i++) begin
      if (mask[i] && (1 + p_off[i] > L)) L = 1 + p_off[i];
    end
    cs    = L + 1 + COMP_DELAY;
    cd    = cs + p_cdo;
    ss    = cd + 1 + p_drain;
    fifoT = ss + p_fo;
    wmstT = ss + p_wo;
    td    = ((fifoT > wmstT) ? fifoT : wmstT) + 2;
    ab    = ss + 1;
    last  = p_abort ? ab + 1 : td + 1;

    for (int t = 0; t <= last; t++) begin
      ctlObs = {ld_start, compute_start, store_start, tile_done, tile_reset,
                tile_busy, zero_init, err_start_busy};
      if (p_abort && t > ab) begin
        ctlExp = '0;
        cntExp = '0;
      end else begin
        ctlExp = {(t == 1) ? mask : 3'b000, t == cs, t == ss, t == td, t == td + 1,
                  (t >= 1 && t <= td), zi && (t >= 1 && t <= td),
                  errPrev || (p_poke && t >= cs + 2)};
        cntExp = (t <= td) ? countPrev : 32'(td + 1);
      end
      checkOutput($sformatf("ctl t=%0d", t), 64'(ctlObs), 64'(ctlExp));
      checkOutput($sformatf("cycle_count t=%0d", t), 64'(cycle_count), 64'(cntExp));

      rst          = p_abort && (t == ab);
      tile_start   = (t == 0) || (p_poke && t == cs + 1);
      zero_init_en = (t == 0) ? p_zi_en : 1'($urandom % 2);
      tile_base_m  = (t == 0) ? p_base : 16'($urandom);
      drain_cycles = (t == 0) ? 8'(p_drain) : 8'($urandom);
      for (int i = 0; i < 3; i++) begin
        ld_done[i] = mask[i] && (t == 1 + p_off[i]);
      end
      compute_done = (t == cd) || (p_spur && t == 1);
      st_fifo_done = (t == fifoT) || (p_spur && t == 1);
      st_wmst_done = (t == wmstT) || (p_spur && t == 1);
      @(posedge clk);
      #1;
    end

    if (p_abort) begin
      errPrev   = 1'b0;
      countPrev = '0;
    end else begin
      errPrev   = errPrev || p_poke;
      countPrev = 32'(td + 1);
    end
  endtask

  initial begin
    rst          = 1'b1;
    tile_start   = 1'b1;
    tile_base_m  = '0;
    zero_init_en = 1'b1;
    drain_cycles = '0;
    ld_done      = 3'b111;
    compute_done = 1'b1;
    st_fifo_done = 1'b1;
    st_wmst_done = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset ctl", 64'({ld_start, compute_start, store_start, tile_done,
                tile_reset, tile_busy, zero_init, err_start_busy}), 64'd0);
    checkOutput("reset cycle_count", 64'(cycle_count), 64'd0);
    rst          = 1'b0;
    tile_start   = 1'b0;
    ld_done      = '0;
    compute_done = 1'b0;
    st_fifo_done = 1'b0;
    st_wmst_done = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle after reset", 64'({tile_busy, err_start_busy}), 64'd0);

    $display("[TB] baseline tile: loads at +10/+20/+30, compute +100, drain 4");
    planTile(0, 16'h0040, 4, 10, 20, 30, 100, 3, 5, 0, 0, 0);
    applyStimulus();
    $display("[TB] zero-init tile");
    planTile(1, 16'h0000, 2, 5, 8, 40, 10, 2, 2, 0, 0, 0);
    applyStimulus();
    $display("[TB] zero_init_en with nonzero base");
    planTile(1, 16'h0003, 1, 3, 1, 6, 4, 1, 1, 0, 1, 0);
    applyStimulus();
    $display("[TB] write master done before fifo done, then same cycle");
    planTile(0, 16'h0011, 3, 2, 4, 6, 5, 6, 2, 0, 0, 0);
    applyStimulus();
    planTile(0, 16'h0012, 3, 2, 4, 6, 5, 3, 3, 0, 0, 0);
    applyStimulus();
    $display("[TB] start while busy");
    planTile(0, 16'h0020, 2, 1, 2, 3, 8, 2, 4, 1, 0, 0);
    applyStimulus();
    $display("[TB] reset during store, then clean tile");
    planTile(0, 16'h0030, 2, 1, 2, 3, 6, 5, 5, 0, 0, 1);
    applyStimulus();
    planTile(0, 16'h0031, 1, 4, 2, 3, 3, 1, 2, 0, 0, 0);
    applyStimulus();
    $display("[TB] zero drain, loads in the ld_start cycle");
    planTile(0, 16'h0032, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
    applyStimulus();

    $display("[TB] randomized tiles");
    for (int n = 0; n < 25; n++) begin
      bit ab;
      int fo, wo;
      ab = ($urandom % 8) == 0;
      fo = ab ? 3 + int'($urandom % 4) : 1 + int'($urandom % 6);
      wo = ab ? 3 + int'($urandom % 4) : 1 + int'($urandom % 6);
      planTile(1'($urandom % 2), (($urandom % 3) == 0) ? 16'd0 : 16'($urandom),
               int'($urandom % 8), int'($urandom % 16), int'($urandom % 16),
               int'($urandom % 16), 2 + int'($urandom % 19), fo, wo,
               ($urandom % 4) == 0, 1'($urandom % 2), ab);
      applyStimulus();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/conv_tile_seq.md
CONV_TILE_SEQ -- requirements
Module: conv_tile_seq

Interface
REQ-001 SHALL have parameter CW, default 16: tile coordinate width.
REQ-002 SHALL have parameter NUM_LD, default 3: number of load channels (in_fm, weight, out_fm, ...).
REQ-003 SHALL have parameter OUT_LD_IDX, default 2: index of the out_fm load channel.
REQ-004 SHALL have parameter COMP_DELAY, default 5: cycles from all-loads-done to compute_start.
REQ-005 SHALL have parameter DRAIN_W, default 8: width of the drain-delay input.
REQ-006 SHALL have ports as follows; one clock, reset synchronous and active-high:
  clk  in  1  system clock
  rst  in  1  synchronous active-high reset
  tile_start  in  1  one-cycle tile request
  tile_base_m  in  CW  input-channel tile base, sampled at accepted start
  zero_init_en  in  1  enable out_fm zero-init when tile_base_m==0
  drain_cycles  in  DRAIN_W  compute-to-store delay, sampled at accepted start
  ld_start  out  NUM_LD  one-cycle load start per channel
  ld_done  in  NUM_LD  one-cycle load completion per channel
  compute_start  out  1  one-cycle pulse to conv core
  compute_done  in  1  one-cycle pulse from conv core
  store_start  out  1  one-cycle pulse to fifo drain and write master
  st_fifo_done  in  1  internal store-to-fifo done pulse
  st_wmst_done  in  1  write-master done pulse
  zero_init  out  1  level, out_fm accumulators start at zero this tile
  tile_busy  out  1  level, high in every state except IDLE
  tile_done  out  1  one-cycle completion pulse
  tile_reset  out  1  one-cycle pulse, cycle after tile_done
  cycle_count  out  32  cycles of last completed tile
  err_start_busy  out  1  sticky: tile_start seen while busy

Function
REQ-007 SHALL implement states IDLE, LOAD, PRE_COMP, COMPUTE, DRAIN, STORE, DONE.
REQ-008 SHALL, in IDLE on tile_start, sample inputs, clear done flags, go to LOAD, pulse ld_start on the next cycle.
REQ-009 SHALL set zero_init = zero_init_en && tile_base_m==0 at accept, and hold it until IDLE.
REQ-010 SHALL, when zero_init, not pulse ld_start[OUT_LD_IDX] and preset its done flag.
REQ-011 SHALL latch each ld_done bit into a sticky flag, including pulses in the ld_start cycle.
REQ-012 SHALL leave LOAD for PRE_COMP the cycle after all flags are set, in any completion order.
REQ-013 SHALL count COMP_DELAY cycles in PRE_COMP, then pulse compute_start and enter COMPUTE.
REQ-014 SHALL leave COMPUTE on compute_done.
REQ-015 SHALL count drain_cycles in DRAIN; if zero, pulse store_start the cycle after compute_done.
REQ-016 SHALL pulse store_start once on DRAIN exit and enter STORE.
REQ-017 SHALL latch st_fifo_done and st_wmst_done separately; both done, any order or same cycle, -> DONE.
REQ-018 SHALL pulse tile_done in DONE, pulse tile_reset the next cycle (in IDLE), then accept a new start.
REQ-019 SHALL count cycles from accept to tile_done inclusive and load cycle_count at tile_done; saturate at 2^32-1.
REQ-020 SHALL ignore tile_start while busy and set err_start_busy, cleared only by rst.
REQ-021 SHALL ignore done pulses arriving outside their waiting state, except latched ld_done per REQ-011.

Reset
REQ-022 SHALL, on rst, enter IDLE and zero all outputs, flags and counters, aborting any tile without tile_done.
REQ-023 SHALL give rst priority over every simultaneous input.

Structure
REQ-024 SHALL take state encoding and the drain/delay counter width from the shared accelerator package.
REQ-025 SHALL use one sub-module, sticky_done_latch, for the per-channel and store done flags.

Verification
REQ-026 Default params, zero_init_en=0, ld_done at +10/+20/+30, compute_done at +100, drain=4 -> compute_start 6 cycles after last ld_done; store_start 5 cycles after compute_done.
REQ-027 zero_init_en=1, tile_base_m=0 -> ld_start=3'b011, zero_init=1; completes without ld_done[2].
REQ-028 st_wmst_done before st_fifo_done, then both in the same cycle on a second tile -> exactly one tile_done each, tile_reset 1 cycle later.
REQ-029 tile_start during COMPUTE -> ignored, err_start_busy=1, tile completes normally.
REQ-030 rst in STORE -> all outputs 0 the next cycle, no tile_done; new tile then runs clean.
REQ-031 drain=0, ld_done in the same cycle as ld_start -> store_start the cycle after compute_done; cycle_count matches the bench count.
